ball_bounce_controller: RTL and testbench

//  Consumer end of the collision path. Takes the once-per-frame hit pulse and the hit-edge

---
 rtl/ball_bounce_controller_if.sv | 33 +++
 rtl/ball_bounce_controller.sv | 160 ++++++++++++++++
 tb/tb_ball_bounce_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/ball_bounce_controller_if.sv
// rtl/ball_bounce_controller_if.sv - frame/hit/serve inputs and ball outputs of the bounce controller
//
// Purpose: bundles the frame timing, collision and serve inputs together with the
//   ball position and status outputs.
// Signals:
//   startOfFrame  1-clk pulse per frame
//   hit_pulse     1-clk collision pulse from the game controller
//   hit_edge[3:0] touched side [3]top [2]bottom [1]left [0]right, valid with hit_pulse
//   serve         level request to launch the ball
//   topLeftX/Y    signed ball top-left pixel coordinate
//   ball_lost     1-clk pulse when the ball leaves past the bottom edge
//   in_play       ball is live (not parked at the serve position)
// Modports: master = game side (drives inputs), slave = bounce controller.
interface ball_bounce_controller_if;
  logic               startOfFrame;
  logic               hit_pulse;
  logic [3:0]         hit_edge;
  logic               serve;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               ball_lost;
  logic               in_play;

  modport master (
    output startOfFrame, hit_pulse, hit_edge, serve,
    input  topLeftX, topLeftY, ball_lost, in_play
  );

  modport slave (
    input  startOfFrame, hit_pulse, hit_edge, serve,
    output topLeftX, topLeftY, ball_lost, in_play
  );
endinterface

// File: rtl/ball_bounce_controller.sv
// rtl/ball_bounce_controller.sv - reflects ball velocity on hits/walls and integrates position per frame
//
// Purpose: collects hit edges during a frame, reflects the velocity once per frame,
//   then moves the ball by one velocity step. A ball leaving past the bottom edge
//   pulses ball_lost and is parked at the serve position until serve is seen on a
//   startOfFrame.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    ball_bounce_controller_if.slave (frame/hit/serve in, position/status out)
// Configuration: define BALL_SPEEDUP_EN to raise |vy| by SPEEDUP_STEP (capped at
//   MAX_SPEED) on every frame in which a hit-edge reflection is applied.
module ball_bounce_controller #(
  parameter int INIT_X       = 280,
  parameter int INIT_Y       = 185,
  parameter int INIT_VX      = 64,
  parameter int INIT_VY      = -128,
  parameter int FIXED_SHIFT  = 6,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int OBJ_SIZE     = 16,
  parameter int SPEEDUP_STEP = 8,
  parameter int MAX_SPEED    = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  ball_bounce_controller_if.slave  bus
);

  localparam int POS_W = 11 + FIXED_SHIFT;

  localparam logic signed [POS_W-1:0] INIT_PX = POS_W'(INIT_X * (1 << FIXED_SHIFT));
  localparam logic signed [POS_W-1:0] INIT_PY = POS_W'(INIT_Y * (1 << FIXED_SHIFT));
  localparam logic signed [POS_W-1:0] INIT_V_X = POS_W'(INIT_VX);
  localparam logic signed [POS_W-1:0] INIT_V_Y = POS_W'(INIT_VY);
  localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - OBJ_SIZE);
  localparam logic signed [10:0] Y_LOST = 11'(SCREEN_H);

  typedef enum logic [1:0] {S_SERVE, S_RUN, S_UPD_V, S_UPD_P} state_t;

  state_t state, state_nxt;

  logic signed [POS_W-1:0] pos_x, pos_y, vel_x, vel_y;
  logic [3:0]              pend_edge;
  logic                    lost_q;

  logic signed [10:0]      pix_x, pix_y, new_pix_y;
  logic signed [POS_W-1:0] sum_x, sum_y;
  logic signed [POS_W-1:0] abs_vx, abs_vy, vy_mag;
  logic signed [POS_W-1:0] vx_new, vy_new;
  logic                    edge_x, edge_y, lost;

  // Arithmetic shift right by FIXED_SHIFT, low 11 bits, is exactly the top slice.
  assign pix_x     = pos_x[POS_W-1:FIXED_SHIFT];
  assign pix_y     = pos_y[POS_W-1:FIXED_SHIFT];
  assign sum_x     = pos_x + vel_x;
  assign sum_y     = pos_y + vel_y;
  assign new_pix_y = sum_y[POS_W-1:FIXED_SHIFT];
  assign lost      = (new_pix_y >= Y_LOST);

  assign abs_vx = vel_x[POS_W-1] ? -vel_x : vel_x;
  assign abs_vy = vel_y[POS_W-1] ? -vel_y : vel_y;

  // Opposite edges hit together cancel out, so only a lone edge reflects.
  assign edge_x = pend_edge[1] ^ pend_edge[0];
  assign edge_y = pend_edge[3] ^ pend_edge[2];

`ifdef BALL_SPEEDUP_EN
  localparam logic signed [POS_W-1:0] STEP_V = POS_W'(SPEEDUP_STEP);
  localparam logic signed [POS_W-1:0] MAX_V  = POS_W'(MAX_SPEED);
  logic signed [POS_W-1:0] vy_fast;
  assign vy_fast = abs_vy + STEP_V;
  assign vy_mag  = (edge_x || edge_y) ? ((vy_fast > MAX_V) ? MAX_V : vy_fast) : abs_vy;
`else
  logic unused_speedup_cfg;
  assign unused_speedup_cfg = ^{SPEEDUP_STEP[0], MAX_SPEED[0]};
  assign vy_mag = abs_vy;
`endif

  // Hit edges first, then walls; a wall always forces travel back into the field.
  always_comb begin
    vx_new = vel_x;
    vy_new = vel_y[POS_W-1] ? -vy_mag : vy_mag;
    if (edge_y) vy_new = pend_edge[3] ? vy_mag : -vy_mag;
    if (edge_x) vx_new = pend_edge[1] ? abs_vx : -abs_vx;
    if (pix_x <= 11'sd0)     vx_new = abs_vx;
    else if (pix_x >= X_MAX) vx_new = -abs_vx;
    if (pix_y <= 11'sd0)     vy_new = vy_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_SERVE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SERVE: if (bus.serve && bus.startOfFrame) state_nxt = S_RUN;
      S_RUN:   if (bus.startOfFrame) state_nxt = S_UPD_V;
      S_UPD_V: state_nxt = S_UPD_P;
      S_UPD_P: state_nxt = lost ? S_SERVE : S_RUN;
      default: state_nxt = S_SERVE;
    endcase
  end

  always_comb begin
    bus.topLeftX  = pix_x;
    bus.topLeftY  = pix_y;
    bus.ball_lost = lost_q;
    bus.in_play   = (state != S_SERVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x     <= INIT_PX;
      pos_y     <= INIT_PY;
      vel_x     <= INIT_V_X;
      vel_y     <= INIT_V_Y;
      pend_edge <= 4'b0000;
      lost_q    <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      case (state)
        S_SERVE: begin
          pos_x     <= INIT_PX;
          pos_y     <= INIT_PY;
          vel_x     <= INIT_V_X;
          vel_y     <= INIT_V_Y;
          pend_edge <= 4'b0000;
        end
        S_RUN: begin
          if (bus.hit_pulse) pend_edge <= pend_edge | bus.hit_edge;
        end
        S_UPD_V: begin
          vel_x <= vx_new;
          vel_y <= vy_new;
          // A pulse landing on this clock belongs to the next frame.
          pend_edge <= bus.hit_pulse ? bus.hit_edge : 4'b0000;
        end
        S_UPD_P: begin
          if (lost) begin
            pos_x     <= INIT_PX;
            pos_y     <= INIT_PY;
            vel_x     <= INIT_V_X;
            vel_y     <= INIT_V_Y;
            pend_edge <= 4'b0000;
            lost_q    <= 1'b1;
          end else begin
            pos_x <= sum_x;
            pos_y <= sum_y;
            if (bus.hit_pulse) pend_edge <= pend_edge | bus.hit_edge;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_bounce_controller.sv
// tb/tb_ball_bounce_controller.sv - directed self-checking bench for ball_bounce_controller
module tb_ball_bounce_controller;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  ball_bounce_controller_if bus ();

  ball_bounce_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: startOfFrame, UPD_V clock, UPD_P clock. Returns with the new position visible.
  task automatic frame(input logic hit_sof, input logic hit_updv, input logic [3:0] e_v);
    bus.startOfFrame = 1'b1;
    bus.hit_pulse    = hit_sof;
    bus.hit_edge     = e_v;
    tick();
    bus.startOfFrame = 1'b0;
    bus.hit_pulse    = hit_updv;
    tick();
    bus.hit_pulse    = 1'b0;
    bus.hit_edge     = 4'b0000;
    tick();
  endtask

  task automatic hit_run(input logic [3:0] e_v);
    bus.hit_pulse = 1'b1;
    bus.hit_edge  = e_v;
    tick();
    bus.hit_pulse = 1'b0;
    bus.hit_edge  = 4'b0000;
  endtask

  task automatic check_xy(input string name, input int ex, input int ey);
    tests_run++;
    if (bus.topLeftX !== 11'(ex) || bus.topLeftY !== 11'(ey)) begin
      tests_failed++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name,
               bus.topLeftX, bus.topLeftY, ex, ey);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic do_serve();
    bus.serve = 1'b1;
    frame(1'b0, 1'b0, 4'b0000);
    bus.serve = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    check_xy("reset_pos", 280, 185);
    tests_run++;
    if (bus.in_play !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_play: got %b expected 0", bus.in_play);
    end
    tests_run++;
    if (bus.ball_lost !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ball_lost: got %b expected 0", bus.ball_lost);
    end
  endtask

  task automatic test_serve();
    do_serve();
    tests_run++;
    if (bus.in_play !== 1'b1) begin
      tests_failed++;
      $display("FAIL serve_in_play: got %b expected 1", bus.in_play);
    end
    check_xy("serve_hold", 280, 185);
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("first_move", 281, 183);
  endtask

  task automatic test_hit_top();
    hit_run(4'b1000);
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("top_hit", 282, 185);
  endtask

  task automatic test_sof_hit();
    frame(1'b1, 1'b0, 4'b0001);
    check_xy("sof_hit_right", 281, 187);
    // Left hit landing in UPD_V must not affect this frame.
    frame(1'b0, 1'b1, 4'b0010);
    check_xy("updv_hit_deferred", 280, 189);
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("updv_hit_applied", 281, 191);
  endtask

  task automatic test_both_edges();
    hit_run(4'b1100);
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("top_bottom_cancel", 282, 193);
  endtask

  task automatic test_right_wall();
    for (int i = 0; i < 342; i++) begin
      hit_run((i % 2 == 0) ? 4'b0100 : 4'b1000);
      frame(1'b0, 1'b0, 4'b0000);
    end
    check_xy("reach_right_wall", 624, 193);
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("right_wall_bounce", 623, 195);
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("after_wall", 622, 197);
  endtask

  task automatic test_lost();
    for (int i = 0; i < 141; i++) frame(1'b0, 1'b0, 4'b0000);
    check_xy("y_479", 481, 479);
    frame(1'b0, 1'b0, 4'b0000);
    tests_run++;
    if (bus.ball_lost !== 1'b1 || bus.in_play !== 1'b0) begin
      tests_failed++;
      $display("FAIL lost_pulse: got lost=%b in_play=%b expected lost=1 in_play=0",
               bus.ball_lost, bus.in_play);
    end
    check_xy("lost_reload", 280, 185);
    tick();
    tests_run++;
    if (bus.ball_lost !== 1'b0) begin
      tests_failed++;
      $display("FAIL lost_one_clk: got %b expected 0", bus.ball_lost);
    end
    hit_run(4'b1000);
    do_serve();
    frame(1'b0, 1'b0, 4'b0000);
    check_xy("serve_hit_ignored", 281, 183);
  endtask

  task automatic test_speed();
    int y_fp;
    int v;
    int mag;
    do_reset();
    do_serve();
    y_fp = 185 * 64;
    v    = -128;
    for (int k = 0; k < 70; k++) begin
      hit_run((k % 2 == 0) ? 4'b0100 : 4'b1000);
      frame(1'b0, 1'b0, 4'b0000);
      mag = (v < 0) ? -v : v;
`ifdef BALL_SPEEDUP_EN
      mag = (mag + 8 > 512) ? 512 : mag + 8;
`endif
      v = (k % 2 == 0) ? -mag : mag;
      y_fp = y_fp + v;
    end
    check_xy("after_70_hits", 350, y_fp / 64);
    frame(1'b0, 1'b0, 4'b0000);
    y_fp = y_fp + v;
    check_xy("speed_final", 351, y_fp / 64);
    tests_run++;
`ifdef BALL_SPEEDUP_EN
    if (v !== 512) begin
`else
    if (v !== 128) begin
`endif
      tests_failed++;
      $display("FAIL speed_model: got %0d", v);
    end
  endtask

  task automatic test_reset_mid_update();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
    #1;
    reset = 1'b1;
    #1;
    check_xy("reset_mid_upd_p", 280, 185);
    tests_run++;
    if (bus.in_play !== 1'b0 || bus.ball_lost !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_flags: got in_play=%b lost=%b expected 0 0",
               bus.in_play, bus.ball_lost);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_xy("after_mid_reset", 280, 185);
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    reset            = 1'b1;
    bus.startOfFrame = 1'b0;
    bus.hit_pulse    = 1'b0;
    bus.hit_edge     = 4'b0000;
    bus.serve        = 1'b0;
    test_reset();
    test_serve();
    test_hit_top();
    test_sof_hit();
    test_both_edges();
    test_right_wall();
    test_lost();
    test_speed();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
